mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a variable-latency data-memory request/response handshake.
- Generates the global stall and the MEM/WB bubble.
- Delivers the raw 32-bit load word to MEM/WB (mem_read). Byte extraction stays in WB via LoadByte.

Parameters:
- RESP_TIMEOUT, 64, max cycles in RESP before a bus error is forced.
- ERR_DATA, 32'hDEADBEEF, load data returned on timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_res  in  32  effective address from EX/MEM
- store_data  in  32  rt value from EX/MEM
- MemRead  in  1  load in MEM
- MemWrite  in  1  store in MEM
- StoreByte  in  1  store is byte-wide (sb), else word
- LoadByte  in  2  00 word, else byte load; byte loads skip the alignment check
- dmem_req  out  1  request valid
- dmem_we  out  1  request is write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  write data
- dmem_wstrb  out  4  byte enables
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- mem_read  out  32  load word to MEM/WB
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_bubble  out  1  drives MEM/WB bubble; equals mem_stall
- misaligned  out  1  one-cycle pulse on word access with addr[1:0]!=0
- bus_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset: clk and reset (synchronous, active-high) as already decided.
  - State goes to IDLE; latched address/data/strobe/we, rdata_q and timeout counter clear to 0.
  - All outputs read 0 in the cycle after reset, since IDLE with MemRead=MemWrite=0 gives mem_stall=0 and dmem_req=0.
- access = MemRead | MemWrite. If both are set, treat as load; MemWrite is ignored.
- Word access (MemRead with LoadByte==0, or MemWrite with !StoreByte) with alu_res[1:0]!=0:
  - misaligned=1 combinationally in IDLE, no dmem_req, no stall, mem_read=0; state stays IDLE.
- Store encoding:
  - Word: wstrb=4'hF, wdata=store_data.
  - Byte: wstrb = 4'b0001<<alu_res[1:0], wdata = {4{store_data[7:0]}}.
- IDLE:
  - dmem_req = access & aligned, driven combinationally from live inputs. Latch addr/wdata/wstrb/we every cycle that access holds.
  - Store & ready: completes this cycle. mem_stall=0; stay IDLE.
  - Load & ready: go to RESP; mem_stall=1.
  - Access & !ready: go to REQ; mem_stall=1.
  - mem_read=0 in IDLE except on DONE exit (see DONE).
- REQ:
  - dmem_req=1 from latched fields, held stable until ready. mem_stall=1.
  - On ready: store goes to DONE; load goes to RESP.
- RESP:
  - dmem_req=0, mem_stall=1; the timeout counter increments each cycle.
  - rvalid: capture dmem_rdata into rdata_q, go to DONE.
  - Counter reaches RESP_TIMEOUT-1 without rvalid: rdata_q=ERR_DATA, bus_err pulse on the transition cycle, go to DONE.
  - Counter clears on leaving RESP.
- DONE:
  - mem_stall=0, mem_read=rdata_q (0 for stores). Next state is IDLE unconditionally.
  - The instruction advances into MEM/WB this cycle, so no re-issue occurs.
- rvalid in IDLE/REQ/DONE is ignored; no stale data is captured.
- Earliest rvalid is the cycle after the ready handshake. Same-cycle ready+rvalid in IDLE is not supported; rvalid is ignored there.
- Load latency:
  - Zero-wait memory (ready in IDLE, rvalid next cycle): 2 stall cycles (IDLE, RESP), data in DONE.
  - Stores with immediate ready: 0 stall cycles.
- Reset mid-operation: returns to IDLE next cycle and drops dmem_req. A later rvalid for the abandoned request is ignored.
- mem_bubble == mem_stall at all times, so MEM/WB captures a bubble while the stage is stalled.

Test Plan:
- Reset, then idle cycles -> dmem_req=0, mem_stall=0, mem_read=0, misaligned=0, bus_err=0.
- sw addr 0x100 data 0x12345678, ready=1 immediately -> same cycle: dmem_req=1, we=1, wstrb=F, addr=0x100; mem_stall=0; no second request next cycle.
- lw addr 0x204, ready after 2 cycles, rvalid 3 cycles later with 0xCAFEF00D -> dmem_addr stable 0x204 throughout REQ. mem_stall=1 for 6 cycles, then DONE with mem_read=0xCAFEF00D, stall=0. Exactly one request.
- sb addr 0x103 data 0x000000AB -> wstrb=4'b1000, wdata=0xABABABAB, addr=0x100.
- lw addr 0x202 -> misaligned=1 for one cycle, no dmem_req, mem_stall=0. lb addr 0x202 -> normal request to 0x200.
- lw, ready, no rvalid -> after RESP_TIMEOUT cycles in RESP: bus_err pulse, mem_read=0xDEADBEEF in DONE. Then assert reset during a REQ wait -> next cycle IDLE, dmem_req=0; a late rvalid is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests over a ready/rvalid
// handshake, stalls the pipeline while an access is outstanding, bounds the
// response wait with a timeout, and hands the raw load word to MEM/WB.
module mem_access_stage #(
    parameter int          RESP_TIMEOUT = 64,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        StoreByte,
    input  logic [1:0]  LoadByte,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_read,
    output logic        mem_stall,
    output logic        mem_bubble,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW       = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

    logic [1:0]    state_reg, state_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [3:0]    wstrb_reg, wstrb_next;
    logic          we_reg, we_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Decode of the instruction currently sitting in EX/MEM. A load wins
    // when both MemRead and MemWrite are set.
    logic        access;
    logic        is_store;
    logic        word_access;
    logic        misaligned_now;
    logic [31:0] live_addr;
    logic [31:0] live_wdata;
    logic [3:0]  live_wstrb;
    logic [31:0] byte_wdata;

    assign access         = MemRead | MemWrite;
    assign is_store       = MemWrite & ~MemRead;
    assign word_access    = MemRead ? (LoadByte == 2'b00) : (MemWrite & ~StoreByte);
    assign misaligned_now = word_access & (alu_res[1:0] != 2'b00);
    assign live_addr      = {alu_res[31:2], 2'b00};

    // Byte stores replicate the low byte onto every lane; the strobe picks the lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_wdata[gi*8 +: 8] = store_data[7:0];
        end
    endgenerate

    assign live_wdata = (is_store & StoreByte) ? byte_wdata : store_data;
    assign live_wstrb = ~is_store ? 4'h0 :
                        (StoreByte ? (4'b0001 << alu_res[1:0]) : 4'hF);

    assign mem_bubble = mem_stall;

    // Next-state, handshake outputs, stall and result selection.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        we_next    = we_reg;
        rdata_next = rdata_reg;
        cnt_next   = cnt_reg;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        mem_stall  = 1'b0;
        mem_read   = 32'd0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                misaligned = access & misaligned_now;
                if (access) begin
                    addr_next  = live_addr;
                    wdata_next = live_wdata;
                    wstrb_next = live_wstrb;
                    we_next    = is_store;
                end
                if (access && !misaligned_now) begin
                    dmem_req   = 1'b1;
                    dmem_we    = is_store;
                    dmem_addr  = live_addr;
                    dmem_wdata = live_wdata;
                    dmem_wstrb = live_wstrb;
                    if (dmem_ready) begin
                        // A store accepted immediately is finished; a load waits for data.
                        if (!is_store) begin
                            state_next = S_RESP;
                            mem_stall  = 1'b1;
                        end
                    end else begin
                        state_next = S_REQ;
                        mem_stall  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = we_reg;
                dmem_addr  = addr_reg;
                dmem_wdata = wdata_reg;
                dmem_wstrb = wstrb_reg;
                mem_stall  = 1'b1;
                if (dmem_ready) begin
                    state_next = we_reg ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) begin
                    rdata_next = dmem_rdata;
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next = ERR_DATA;
                    bus_err    = 1'b1;
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DONE: begin
                // The instruction moves into MEM/WB now, so never re-issue.
                mem_read   = we_reg ? 32'd0 : rdata_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and latched request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
            we_reg    <= 1'b0;
            rdata_reg <= 32'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            we_reg    <= we_next;
            rdata_reg <= rdata_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized back-to-back
// accesses, each compared with a transaction-level model of stall length,
// request fields, delivered data and error pulses.
module tb_mem_access_stage;

    localparam int          RESP_TIMEOUT = 64;
    localparam logic [31:0] ERR_DATA     = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_res, store_data;
    logic        MemRead, MemWrite, StoreByte;
    logic [1:0]  LoadByte;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata, mem_read;
    logic        mem_stall, mem_bubble, misaligned, bus_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.RESP_TIMEOUT(RESP_TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .reset(reset), .alu_res(alu_res), .store_data(store_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .StoreByte(StoreByte), .LoadByte(LoadByte),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_read(mem_read),
        .mem_stall(mem_stall), .mem_bubble(mem_bubble), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    // Summary of one access as seen on the ports.
    typedef struct {
        int          ncyc;
        int          n_stall;
        int          n_req;
        int          n_hs;
        int          n_buserr;
        int          buserr_cyc;
        int          n_mis;
        bit          stable;
        bit          bubble_ok;
        bit          stray;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] done_read;
        logic        done_stall;
    } obs_t;

    // Expected behaviour of one access given the memory's ready delay d
    // (cycles of presentation before acceptance) and data delay r.
    task automatic model(input bit ld, input bit byt, input logic [31:0] a,
                         input logic [31:0] sd, input int d, input int r,
                         input bit tmo, input logic [31:0] rd, output obs_t e);
        e = '{default: 0};
        e.n_req      = d + 1;
        e.n_hs       = 1;
        e.stable     = 1'b1;
        e.bubble_ok  = 1'b1;
        e.addr       = a & 32'hFFFF_FFFC;
        e.we         = !ld;
        e.wstrb      = byt ? 4'(32'd1 << a[1:0]) : 4'hF;
        e.wdata      = byt ? sd[7:0] * 32'h0101_0101 : sd;
        if (ld) e.n_stall = d + 1 + (tmo ? RESP_TIMEOUT : r);
        else    e.n_stall = (d == 0) ? 0 : d + 1;
        e.done_read  = ld ? (tmo ? ERR_DATA : rd) : 32'd0;
        e.n_buserr   = tmo ? 1 : 0;
        e.buserr_cyc = tmo ? d + RESP_TIMEOUT : -1;
        e.ncyc       = e.n_stall + 1;
    endtask

    // Drives one access with a scripted memory and records what the ports did.
    task automatic run_access(input bit ld, input bit byt, input bit both,
                              input logic [31:0] a, input logic [31:0] sd,
                              input int d, input int r, input bit tmo,
                              input logic [31:0] rd, input int ncyc, output obs_t o);
        bit first;
        bit real_rv;
        o = '{default: 0};
        o.stable     = 1'b1;
        o.bubble_ok  = 1'b1;
        o.buserr_cyc = -1;
        o.ncyc       = ncyc;
        MemRead    = ld;
        MemWrite   = !ld || both;
        StoreByte  = byt;
        LoadByte   = (ld && byt) ? 2'($urandom_range(1, 3)) : 2'b00;
        alu_res    = a;
        store_data = sd;
        first      = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            real_rv     = ld && !tmo && (c == d + r);
            dmem_ready  = (c == d) ? 1'b1 : ((c > d) ? 1'($urandom_range(0, 1)) : 1'b0);
            dmem_rvalid = real_rv || ((c <= d || c == ncyc - 1) && ($urandom_range(0, 2) == 0));
            dmem_rdata  = real_rv ? rd : $urandom;
            @(negedge clk);
            if (mem_stall) o.n_stall++;
            if (mem_bubble !== mem_stall) o.bubble_ok = 1'b0;
            if (misaligned) o.n_mis++;
            if (bus_err) begin o.n_buserr++; o.buserr_cyc = c; end
            if (dmem_req) begin
                o.n_req++;
                if (dmem_ready) o.n_hs++;
                if (first) begin
                    o.addr = dmem_addr; o.we = dmem_we; o.wdata = dmem_wdata; o.wstrb = dmem_wstrb;
                    first  = 1'b0;
                end else if (dmem_addr !== o.addr || dmem_we !== o.we ||
                             dmem_wdata !== o.wdata || dmem_wstrb !== o.wstrb) begin
                    o.stable = 1'b0;
                end
            end
            if (c == ncyc - 1) begin
                o.done_read  = mem_read;
                o.done_stall = mem_stall;
            end else if (mem_read !== 32'd0) begin
                o.stray = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_idle();
        MemRead = 0; MemWrite = 0; StoreByte = 0; LoadByte = 0;
        alu_res = 0; store_data = 0; dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({dmem_req, mem_stall, mem_bubble, misaligned, bus_err} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_ctrl: got req/stall/bub/mis/err=%b required 00000",
                         {dmem_req, mem_stall, mem_bubble, misaligned, bus_err});
            end
            n_vec++;
            if ({mem_read, dmem_addr, dmem_wdata, dmem_wstrb, dmem_we} !== 101'd0) begin
                n_err++;
                $display("FAIL reset_data: got mem_read=%h addr=%h wdata=%h wstrb=%h we=%b required all 0",
                         mem_read, dmem_addr, dmem_wdata, dmem_wstrb, dmem_we);
            end
            @(posedge clk); #1;
        end
        $display("txn reset: idle outputs checked");
    endtask

    task automatic test_store_word();
        obs_t e, o;
        model(0, 0, 32'h100, 32'h12345678, 0, 0, 0, 0, e);
        run_access(0, 0, 0, 32'h100, 32'h12345678, 0, 0, 0, 0, e.ncyc, o);
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (o.n_stall !== 0 || o.n_req !== 1) begin
            n_err++; $display("FAIL sw_stall: got stalls=%0d reqs=%0d required 0/1", o.n_stall, o.n_req);
        end
        n_vec++;
        if ({o.addr, o.we, o.wstrb, o.wdata} !== {32'h100, 1'b1, 4'hF, 32'h12345678}) begin
            n_err++; $display("FAIL sw_fields: got addr=%h we=%b wstrb=%h wdata=%h required 100/1/f/12345678",
                              o.addr, o.we, o.wstrb, o.wdata);
        end
        n_vec++;
        if (dmem_req !== 1'b0) begin
            n_err++; $display("FAIL sw_no_reissue: got dmem_req=%b required 0", dmem_req);
        end
        @(posedge clk); #1;
        $display("txn sw addr=%h stalls=%0d", o.addr, o.n_stall);
    endtask

    task automatic test_load_wait();
        obs_t e, o;
        model(1, 0, 32'h204, 32'h0, 2, 3, 0, 32'hCAFEF00D, e);
        run_access(1, 0, 0, 32'h204, 32'h0, 2, 3, 0, 32'hCAFEF00D, e.ncyc, o);
        n_vec++;
        if (o.n_stall !== 6) begin
            n_err++; $display("FAIL lw_stall: got %0d stall cycles required 6", o.n_stall);
        end
        n_vec++;
        if (o.done_read !== 32'hCAFEF00D || o.done_stall !== 1'b0) begin
            n_err++; $display("FAIL lw_data: got mem_read=%h stall=%b required cafef00d/0", o.done_read, o.done_stall);
        end
        n_vec++;
        if (o.n_hs !== 1 || !o.stable || o.addr !== 32'h204) begin
            n_err++; $display("FAIL lw_req: got handshakes=%0d stable=%b addr=%h required 1/1/204",
                              o.n_hs, o.stable, o.addr);
        end
        $display("txn lw addr=%h stalls=%0d data=%h", o.addr, o.n_stall, o.done_read);
    endtask

    task automatic test_store_byte();
        obs_t e, o;
        model(0, 1, 32'h103, 32'hAB, 0, 0, 0, 0, e);
        run_access(0, 1, 0, 32'h103, 32'hAB, 0, 0, 0, 0, e.ncyc, o);
        n_vec++;
        if ({o.addr, o.wstrb, o.wdata} !== {32'h100, 4'b1000, 32'hABABABAB}) begin
            n_err++; $display("FAIL sb_fields: got addr=%h wstrb=%b wdata=%h required 100/1000/abababab",
                              o.addr, o.wstrb, o.wdata);
        end
        $display("txn sb addr=%h wstrb=%b wdata=%h", o.addr, o.wstrb, o.wdata);
    endtask

    task automatic test_misaligned();
        obs_t e, o;
        // lw to 0x202, then sw to 0x201: both flagged, neither requested.
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            if (k == 0) begin MemRead = 1; alu_res = 32'h202; end
            else begin MemWrite = 1; alu_res = 32'h201; end
            dmem_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({misaligned, dmem_req, mem_stall, mem_read} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
                n_err++; $display("FAIL misaligned_%0d: got mis=%b req=%b stall=%b read=%h required 1/0/0/0",
                                  k, misaligned, dmem_req, mem_stall, mem_read);
            end
            @(posedge clk); #1;
            $display("txn misaligned %s addr=%h", (k == 0) ? "lw" : "sw", alu_res);
        end
        drive_idle();
        @(negedge clk);
        n_vec++;
        if ({misaligned, dmem_req, mem_stall} !== 3'b000) begin
            n_err++; $display("FAIL misaligned_after: got mis/req/stall=%b required 000",
                              {misaligned, dmem_req, mem_stall});
        end
        @(posedge clk); #1;
        model(1, 1, 32'h202, 32'h0, 0, 1, 0, 32'h0BADF00D, e);
        run_access(1, 1, 0, 32'h202, 32'h0, 0, 1, 0, 32'h0BADF00D, e.ncyc, o);
        n_vec++;
        if (o.n_mis !== 0 || o.addr !== 32'h200 || o.done_read !== 32'h0BADF00D) begin
            n_err++; $display("FAIL lb_unaligned: got mis=%0d addr=%h read=%h required 0/200/0badf00d",
                              o.n_mis, o.addr, o.done_read);
        end
        $display("txn lb addr=%h data=%h", o.addr, o.done_read);
    endtask

    task automatic test_timeout();
        obs_t e, o;
        model(1, 0, 32'h400, 32'h0, 1, 0, 1, 0, e);
        run_access(1, 0, 0, 32'h400, 32'h0, 1, 0, 1, 0, e.ncyc, o);
        n_vec++;
        if (o.n_buserr !== 1 || o.buserr_cyc !== e.buserr_cyc) begin
            n_err++; $display("FAIL timeout_pulse: got %0d pulses at cycle %0d required 1 at %0d",
                              o.n_buserr, o.buserr_cyc, e.buserr_cyc);
        end
        n_vec++;
        if (o.done_read !== ERR_DATA || o.n_stall !== e.n_stall) begin
            n_err++; $display("FAIL timeout_data: got read=%h stalls=%0d required %h/%0d",
                              o.done_read, o.n_stall, ERR_DATA, e.n_stall);
        end
        $display("txn lw timeout stalls=%0d data=%h", o.n_stall, o.done_read);
    endtask

    task automatic test_reset_midop();
        obs_t e, o;
        drive_idle();
        MemRead = 1; alu_res = 32'h308;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h308) begin
                n_err++; $display("FAIL midop_req: got req=%b addr=%h required 1/308", dmem_req, dmem_addr);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; MemRead = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_err++; $display("FAIL midop_reset: got req=%b stall=%b required 0/0", dmem_req, mem_stall);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555AAAA;
        @(negedge clk);
        n_vec++;
        if (mem_read !== 32'd0 || mem_stall !== 1'b0) begin
            n_err++; $display("FAIL midop_late_rvalid: got read=%h stall=%b required 0/0", mem_read, mem_stall);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        model(1, 0, 32'h30C, 32'h0, 0, 1, 0, 32'h13572468, e);
        run_access(1, 0, 0, 32'h30C, 32'h0, 0, 1, 0, 32'h13572468, e.ncyc, o);
        n_vec++;
        if (o.done_read !== 32'h13572468 || o.n_stall !== e.n_stall) begin
            n_err++; $display("FAIL midop_next_load: got read=%h stalls=%0d required 13572468/%0d",
                              o.done_read, o.n_stall, e.n_stall);
        end
        $display("txn reset mid-request, follow-up lw data=%h", o.done_read);
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        bit ld, byt, both;
        int kind, d, r;
        logic [31:0] a, sd, rd;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            ld   = (kind < 2);
            byt  = (kind == 1 || kind == 3);
            both = ld && ($urandom_range(0, 3) == 0);
            a    = $urandom;
            if (!byt) a[1:0] = 2'b00;
            sd   = $urandom;
            rd   = $urandom;
            d    = $urandom_range(0, 3);
            r    = $urandom_range(1, 4);
            model(ld, byt, a, sd, d, r, 0, rd, e);
            run_access(ld, byt, both, a, sd, d, r, 0, rd, e.ncyc, o);
            n_vec++;
            if (o.n_stall !== e.n_stall || o.n_req !== e.n_req || o.n_hs !== e.n_hs) begin
                n_err++; $display("FAIL b2b_%0d_timing: got stall/req/hs=%0d/%0d/%0d required %0d/%0d/%0d",
                                  t, o.n_stall, o.n_req, o.n_hs, e.n_stall, e.n_req, e.n_hs);
            end
            n_vec++;
            if (o.addr !== e.addr || o.we !== e.we || !o.stable) begin
                n_err++; $display("FAIL b2b_%0d_req: got addr=%h we=%b stable=%b required %h/%b/1",
                                  t, o.addr, o.we, o.stable, e.addr, e.we);
            end
            n_vec++;
            if (o.done_read !== e.done_read || o.done_stall !== 1'b0 || o.stray) begin
                n_err++; $display("FAIL b2b_%0d_read: got read=%h stall=%b stray=%b required %h/0/0",
                                  t, o.done_read, o.done_stall, o.stray, e.done_read);
            end
            n_vec++;
            if (o.n_buserr !== 0 || o.n_mis !== 0 || !o.bubble_ok) begin
                n_err++; $display("FAIL b2b_%0d_flags: got buserr=%0d mis=%0d bubble_ok=%b required 0/0/1",
                                  t, o.n_buserr, o.n_mis, o.bubble_ok);
            end
            if (!ld) begin
                n_vec++;
                if (o.wstrb !== e.wstrb || o.wdata !== e.wdata) begin
                    n_err++; $display("FAIL b2b_%0d_wdata: got wstrb=%h wdata=%h required %h/%h",
                                      t, o.wstrb, o.wdata, e.wstrb, e.wdata);
                end
            end
            $display("txn %0d %s addr=%h d=%0d r=%0d stalls=%0d read=%h", t,
                     ld ? (byt ? "lb" : "lw") : (byt ? "sb" : "sw"), a, d, r, o.n_stall, o.done_read);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_wait();
        test_store_byte();
        test_misaligned();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
